// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that grants one requester at a time
// a single memory port for one command plus its data burst.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no burst open; pick next requester round-robin, latch command
// CMD   | command presented to memory; wait for mem_cmd_ready
// DATA  | data beats routed to/from the granted requester until last beat
module mem_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 8,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]              req_rd_wrn,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              req_data_valid,
  input  logic [NUM_REQ-1:0]              req_data_ready,
  output logic                            mem_cmd_valid,
  input  logic                            mem_cmd_ready,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            mem_rd_wrn,
  output logic [LEN_WIDTH-1:0]            mem_len,
  input  logic                            mem_data_valid,
  output logic                            mem_data_ready,
  output logic [IDW-1:0]                  grant_id,
  output logic                            busy,
  output logic                            done
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IDW-1:0]        r_last_ptr;
  logic [IDW-1:0]        r_grant_id;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_rd_wrn;
  logic [LEN_WIDTH-1:0]  r_mem_len;

  logic                  w_found;
  logic [IDW-1:0]        w_pick;
  logic [IDW-1:0]        w_cand;
  logic [NUM_REQ-1:0]    w_grant_oh;
  logic                  w_beat;
  logic                  w_last;

  // Round-robin search starting just after the last completed grant.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDW'((int'(r_last_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;
  assign w_beat     = (r_state == DATA) && mem_data_valid && req_data_ready[r_grant_id];
  assign w_last     = w_beat && (r_beat_cnt == r_mem_len);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and all handshake/gating outputs, decoded from the state.
  always_comb begin
    w_next         = r_state;
    mem_cmd_valid  = 1'b0;
    req_ready      = '0;
    mem_data_ready = 1'b0;
    req_data_valid = '0;
    busy           = 1'b0;
    done           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) w_next = CMD;
      end
      CMD: begin
        busy          = 1'b1;
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) begin
          req_ready = w_grant_oh;
          w_next    = DATA;
        end
      end
      DATA: begin
        busy           = 1'b1;
        mem_data_ready = req_data_ready[r_grant_id];
        req_data_valid = mem_data_valid ? w_grant_oh : '0;
        if (w_last) begin
          done   = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Command latch, grant bookkeeping and beat counter.
  // The final beat is detected by compare, so beat_cnt never wraps even at
  // the maximum burst length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_ptr   <= IDW'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_beat_cnt   <= '0;
      r_mem_addr   <= '0;
      r_mem_rd_wrn <= 1'b0;
      r_mem_len    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id   <= w_pick;
            r_mem_addr   <= req_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
            r_mem_rd_wrn <= req_rd_wrn[w_pick];
            r_mem_len    <= req_len[int'(w_pick)*LEN_WIDTH +: LEN_WIDTH];
          end
        end
        CMD: begin
          if (mem_cmd_ready) r_beat_cnt <= '0;
        end
        DATA: begin
          if (w_last)      r_last_ptr <= r_grant_id;
          else if (w_beat) r_beat_cnt <= r_beat_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_rd_wrn = r_mem_rd_wrn;
  assign mem_len    = r_mem_len;
  assign grant_id   = r_grant_id;

endmodule
